// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, default bit period and
// width helpers used by both the transmitter and the future receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 868;

  // Smallest r with 2**r >= value, never below 1 so counters stay at least one bit wide.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Even parity over up to 9 data bits; narrower words are zero-extended by the caller.
  function automatic logic even_parity(input logic [8:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: tick is high on the last clk cycle of each serial bit.
// restart reloads the count so the next cycle is the first of a new bit.
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = clog2(CLKS_PER_BIT);

  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_next_s;
  logic             tick_r;

  // Next count: wrap on a bit boundary or when a new frame is accepted.
  always_comb begin
    count_next_s = '0;
    if (restart || tick_r) begin
      count_next_s = '0;
    end else begin
      count_next_s = count_r + CNT_W'(1);
    end
  end

  // Count register with a registered boundary flag so tick is glitch-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= '0;
      tick_r  <= 1'b0;
    end else begin
      count_r <= count_next_s;
      tick_r  <= (count_next_s == CNT_W'(CLKS_PER_BIT - 1));
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts a word on a valid/ready handshake and shifts it out
// as start, data LSB-first, optional even parity and one or two stop bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int width        = 8,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [width-1:0] data_in,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             tx,
  output logic             busy,
  output logic             tx_done
);

  localparam int BIT_IDX_W = clog2(width);

  state_t               state_r;
  logic [width-1:0]     shift_r;
  logic                 parity_r;
  logic [BIT_IDX_W-1:0] bit_idx_r;
  logic                 stop_idx_r;
  logic                 tx_r;
  logic                 tick_s;
  logic                 accept_s;
  logic                 stop_last_s;
  logic                 last_stop_s;

  assign stop_last_s = (stop_idx_r == 1'(STOP_BITS - 1));
  assign last_stop_s = (state_r == STOP) && tick_s && stop_last_s;
  assign tx_ready    = (state_r == IDLE) || last_stop_s;
  assign accept_s    = tx_valid && tx_ready;
  assign tx_done     = last_stop_s;
  assign busy        = (state_r != IDLE);
  assign tx          = tx_r;

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .reset  (reset),
    .restart(accept_s),
    .tick   (tick_s)
  );

  // Frame sequencer; tx is driven from a register so the line never glitches between bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      shift_r    <= '0;
      parity_r   <= 1'b0;
      bit_idx_r  <= '0;
      stop_idx_r <= 1'b0;
      tx_r       <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          tx_r <= 1'b1;
          if (accept_s) begin
            state_r  <= START;
            shift_r  <= data_in;
            parity_r <= even_parity(9'(data_in));
            tx_r     <= 1'b0;
          end
        end
        START: begin
          if (tick_s) begin
            state_r   <= DATA;
            bit_idx_r <= '0;
            tx_r      <= shift_r[0];
            shift_r   <= shift_r >> 1;
          end
        end
        DATA: begin
          if (tick_s) begin
            if (bit_idx_r == BIT_IDX_W'(width - 1)) begin
              if (PARITY_EN != 0) begin
                state_r <= PARITY;
                tx_r    <= parity_r;
              end else begin
                state_r    <= STOP;
                stop_idx_r <= 1'b0;
                tx_r       <= 1'b1;
              end
            end else begin
              bit_idx_r <= bit_idx_r + BIT_IDX_W'(1);
              tx_r      <= shift_r[0];
              shift_r   <= shift_r >> 1;
            end
          end
        end
        PARITY: begin
          if (tick_s) begin
            state_r    <= STOP;
            stop_idx_r <= 1'b0;
            tx_r       <= 1'b1;
          end
        end
        STOP: begin
          if (tick_s) begin
            if (stop_last_s) begin
              // Accepting here chains the next start bit with no idle gap.
              if (accept_s) begin
                state_r  <= START;
                shift_r  <= data_in;
                parity_r <= even_parity(9'(data_in));
                tx_r     <= 1'b0;
              end else begin
                state_r <= IDLE;
                tx_r    <= 1'b1;
              end
            end else begin
              stop_idx_r <= 1'b1;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          tx_r    <= 1'b1;
        end
      endcase
    end
  end

endmodule
